// File: rtl/beltwarn_ctrl_if.sv
// Cabin-switch and dashboard signal bundle for the belt-warning controller.
// The master side drives key, occupancy and buckle inputs; the slave side
// (the controller) returns the lamp, chime, per-seat flags and seat count.
interface beltwarn_ctrl_if #(
    parameter int NSEATS = 4
) ();

    localparam int CW = $clog2(NSEATS + 1);

    logic              K;
    logic [NSEATS-1:0] P;
    logic [NSEATS-1:0] S;
    logic              W;
    logic              chime;
    logic [NSEATS-1:0] seat_flag;
    logic [CW-1:0]     unbelted_cnt;

    modport master (
        output K, P, S,
        input  W, chime, seat_flag, unbelted_cnt
    );

    modport slave (
        input  K, P, S,
        output W, chime, seat_flag, unbelted_cnt
    );

endinterface

// File: rtl/beltwarn_ctrl.sv
// Seat-belt warning controller.
// Watches seat occupancy and buckle switches while the key is on. A timed
// chime (with a steady lamp) runs when someone is unbelted, then the lamp
// blinks until everyone buckles. Any newly unbelted seat restarts the chime.
// The driver seat is always treated as occupied.
module beltwarn_ctrl #(
    parameter int NSEATS      = 4,
    parameter int TICK_DIV    = 1000,
    parameter int CHIME_TICKS = 6
) (
    input  logic           clk,
    input  logic           rst,
    beltwarn_ctrl_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(CHIME_TICKS + 1);
    localparam int CW = $clog2(NSEATS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CHIME_TICKS - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_CHIME,
        ST_NAG
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     prescaler_q, prescaler_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              phase_q, phase_d;
    logic [NSEATS-1:0] ub_q, ub_d;
    logic              w_q, w_d;
    logic              chime_q, chime_d;
    logic [NSEATS-1:0] seat_flag_q, seat_flag_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NSEATS-1:0] occ;
    logic [NSEATS-1:0] ub;
    logic [NSEATS-1:0] new_ub;
    logic              tick;
    logic              chime_start;
    logic              nag_entry;

    // Next-state, timer and output decode; outputs derive from the next state so they register alongside it
    always_comb begin
        occ         = bus.P;
        occ[0]      = 1'b1;
        ub          = bus.K ? (occ & ~bus.S) : '0;
        new_ub      = ub & ~ub_q;
        tick        = (prescaler_q == PRE_LAST);

        state_d     = state_q;
        chime_start = 1'b0;
        nag_entry   = 1'b0;

        if (!bus.K) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF, ST_IDLE: begin
                    if (ub != '0) begin
                        state_d     = ST_CHIME;
                        chime_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (ub == '0) begin
                        state_d = ST_IDLE;
                    end else if (new_ub != '0) begin
                        state_d     = ST_CHIME;
                        chime_start = 1'b1;
                    end else if (state_q == ST_CHIME && tick && tick_cnt_q == TICK_LAST) begin
                        state_d   = ST_NAG;
                        nag_entry = 1'b1;
                    end
                end
            endcase
        end

        if (chime_start || nag_entry || tick) begin
            prescaler_d = '0;
        end else begin
            prescaler_d = prescaler_q + PW'(1);
        end

        if (chime_start) begin
            tick_cnt_d = '0;
        end else if (state_q == ST_CHIME && tick) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        if (nag_entry) begin
            phase_d = 1'b1;
        end else if (state_q == ST_NAG && tick) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end

        ub_d        = ub;
        seat_flag_d = ub;
        cnt_d       = '0;
        for (int i = 0; i < NSEATS; i++) begin
            cnt_d = cnt_d + CW'(ub[i]);
        end

        chime_d = (state_d == ST_CHIME);
        w_d     = (state_d == ST_CHIME) || (state_d == ST_NAG && phase_d);
    end

    // Single register bank for FSM state, timers and all outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            prescaler_q <= '0;
            tick_cnt_q  <= '0;
            phase_q     <= 1'b0;
            ub_q        <= '0;
            w_q         <= 1'b0;
            chime_q     <= 1'b0;
            seat_flag_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            tick_cnt_q  <= tick_cnt_d;
            phase_q     <= phase_d;
            ub_q        <= ub_d;
            w_q         <= w_d;
            chime_q     <= chime_d;
            seat_flag_q <= seat_flag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.W            = w_q;
    assign bus.chime        = chime_q;
    assign bus.seat_flag    = seat_flag_q;
    assign bus.unbelted_cnt = cnt_q;

endmodule

// File: tb/tb_beltwarn_ctrl.sv
// Self-checking bench for beltwarn_ctrl: directed scenarios with literal
// expectations plus a long randomized run compared every cycle against a
// cycle-count model of chime duration and blink timing.
module tb_beltwarn_ctrl;

    localparam int NSEATS      = 4;
    localparam int TICK_DIV    = 4;
    localparam int CHIME_TICKS = 3;
    localparam int CHIME_LEN   = CHIME_TICKS * TICK_DIV;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] cur_p;
    logic [3:0] cur_s;
    logic       cur_k;

    beltwarn_ctrl_if #(.NSEATS(NSEATS)) bif ();

    beltwarn_ctrl #(
        .NSEATS     (NSEATS),
        .TICK_DIV   (TICK_DIV),
        .CHIME_TICKS(CHIME_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and log a failure line if it differs
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive new inputs shortly after the next rising edge
    task automatic applyStimulus(input logic k, input logic [3:0] p, input logic [3:0] s);
        @(posedge clk);
        #2;
        bif.K = k;
        bif.P = p;
        bif.S = s;
    endtask

    // Reference model: tracks chime cycles remaining and age of the blink phase
    logic [3:0] m_prev   = '0;
    int         m_left   = 0;
    int         m_age    = -1;
    bit         m_active = 1'b0;
    logic       m_w      = 1'b0;
    logic       m_chime  = 1'b0;
    logic [3:0] m_flag   = '0;
    int         m_cnt    = 0;
    logic [3:0] m_occ;
    logic [3:0] m_ub;

    // Advance the model on every edge; reset wipes it immediately
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = '0; m_left = 0; m_age = -1; m_active = 1'b0;
            m_w = 1'b0; m_chime = 1'b0; m_flag = '0; m_cnt = 0;
        end else begin
            m_occ    = bif.P;
            m_occ[0] = 1'b1;
            m_ub     = bif.K ? (m_occ & ~bif.S) : 4'b0000;
            if (m_ub == 4'b0000) begin
                m_active = 1'b0; m_left = 0; m_age = -1;
            end else if (!m_active || ((m_ub & ~m_prev) != 4'b0000)) begin
                m_active = 1'b1; m_left = CHIME_LEN; m_age = -1;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_age = 0;
            end else begin
                m_age++;
            end
            m_prev  = m_ub;
            m_flag  = m_ub;
            m_cnt   = $countones(m_ub);
            m_chime = (m_left > 0);
            m_w     = m_chime || (m_age >= 0 && ((m_age / TICK_DIV) % 2 == 0));
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        checkOutput("W",            32'(bif.W),            32'(m_w));
        checkOutput("chime",        32'(bif.chime),        32'(m_chime));
        checkOutput("seat_flag",    32'(bif.seat_flag),    32'(m_flag));
        checkOutput("unbelted_cnt", 32'(bif.unbelted_cnt), 32'(m_cnt));
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        rst   = 1'b1;
        bif.K = 1'b0;
        bif.P = 4'b1111;
        bif.S = 4'b0000;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Key off: nothing may be reported even with all seats unbelted
        repeat (5) @(posedge clk);
        #1;
        checkOutput("keyoff_W",     32'(bif.W),            32'd0);
        checkOutput("keyoff_chime", 32'(bif.chime),        32'd0);
        checkOutput("keyoff_flag",  32'(bif.seat_flag),    32'd0);
        checkOutput("keyoff_cnt",   32'(bif.unbelted_cnt), 32'd0);

        // Driver unbelted: 12 cycles of chime, then 4-on/4-off blink
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput("drv_chime", 32'(bif.chime), 32'd1);
            checkOutput("drv_W",     32'(bif.W),     32'd1);
        end
        checkOutput("drv_flag", 32'(bif.seat_flag),    32'h1);
        checkOutput("drv_cnt",  32'(bif.unbelted_cnt), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput("nag_chime", 32'(bif.chime), 32'd0);
            checkOutput("nag_W",     32'(bif.W),     (i / 4) % 2 == 0 ? 32'd1 : 32'd0);
        end

        // New passenger unbelted while nagging restarts the full chime
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput("restart_chime", 32'(bif.chime), 32'd1);
        end
        checkOutput("restart_flag", 32'(bif.seat_flag),    32'h5);
        checkOutput("restart_cnt",  32'(bif.unbelted_cnt), 32'd2);
        @(posedge clk); #1;
        checkOutput("restart_end_chime", 32'(bif.chime), 32'd0);
        checkOutput("restart_end_W",     32'(bif.W),     32'd1);

        // Everyone buckles: lamp and chime clear after one edge
        applyStimulus(1'b1, 4'b0100, 4'b0101);
        @(posedge clk); #1;
        checkOutput("buckle_W",     32'(bif.W),            32'd0);
        checkOutput("buckle_chime", 32'(bif.chime),        32'd0);
        checkOutput("buckle_flag",  32'(bif.seat_flag),    32'd0);
        checkOutput("buckle_cnt",   32'(bif.unbelted_cnt), 32'd0);

        // Empty passenger seat unbuckled is ignored
        applyStimulus(1'b1, 4'b0000, 4'b0011);
        applyStimulus(1'b1, 4'b0000, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("empty_W",     32'(bif.W),     32'd0);
            checkOutput("empty_chime", 32'(bif.chime), 32'd0);
        end

        // Asynchronous reset in the middle of a chime
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_W",     32'(bif.W),            32'd0);
        checkOutput("arst_chime", 32'(bif.chime),        32'd0);
        checkOutput("arst_flag",  32'(bif.seat_flag),    32'd0);
        checkOutput("arst_cnt",   32'(bif.unbelted_cnt), 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput("arst_rechime", 32'(bif.chime), 32'd1);
        end
        @(posedge clk); #1;
        checkOutput("arst_end_chime", 32'(bif.chime), 32'd0);
        checkOutput("arst_end_W",     32'(bif.W),     32'd1);

        // Randomized traffic checked by the model every cycle
        cur_k = 1'b1;
        cur_p = 4'b0000;
        cur_s = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) cur_k = ~cur_k;
            if ($urandom_range(0, 99) < 6) cur_p[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 99) < 12) cur_s[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 99) < 3) cur_s = 4'b1111;
            applyStimulus(cur_k, cur_p, cur_s);
            if ($urandom_range(0, 999) < 3) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
